// File: rtl/icap_arbiter.sv
// Two-port ICAP arbiter: round-robin grant, turnaround gap, transfer-safe release.
// Optional grant watchdog compiled in with `define ICAP_ARB_TIMEOUT_EN.
module icap_arbiter #(
    parameter int unsigned TURNAROUND     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        REQ0,
    input  logic        REQ1,
    output logic        GNT0,
    output logic        GNT1,
    input  logic        CSIB0,
    input  logic        CSIB1,
    input  logic        RDWRB0,
    input  logic        RDWRB1,
    input  logic [31:0] I0,
    input  logic [31:0] I1,
    output logic        AVAIL0,
    output logic        AVAIL1,
    output logic [31:0] O_REQ,
    output logic        TIMEOUT0,
    output logic        TIMEOUT1,
    output logic        ICAP_CSIB,
    output logic        ICAP_RDWRB,
    output logic [31:0] ICAP_I,
    input  logic        ICAP_AVAIL,
    input  logic [31:0] ICAP_O
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WDOG_W = 16;

    if (TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_turnaround
        $error("icap_arbiter: TURNAROUND must be 1..15");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("icap_arbiter: TIMEOUT_CYCLES must be 2..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2,
        S_TURN   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               prio_q, prio_d;     // 1: port 1 wins a tie
    logic               armed_q;            // blocks grants on the first edge after reset release
    logic               gnt0_q, gnt1_q;
    logic [CNT_W-1:0]   turn_cnt_q;
    logic               req0_ok, req1_ok;
    logic               exp0, exp1;

`ifdef ICAP_ARB_TIMEOUT_EN
    logic [WDOG_W-1:0]  wdog_q;
    logic               lock0_q, lock1_q;
    logic               timeout0_q, timeout1_q;

    assign exp0    = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) & CSIB0;
    assign exp1    = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) & CSIB1;
    assign req0_ok = REQ0 & ~lock0_q;
    assign req1_ok = REQ1 & ~lock1_q;

    // Idle-grant watchdog; a revoked port stays locked out until its REQ is seen low
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wdog_q     <= '0;
            lock0_q    <= 1'b0;
            lock1_q    <= 1'b0;
            timeout0_q <= 1'b0;
            timeout1_q <= 1'b0;
        end else begin
            if (state_q == S_GRANT0)
                wdog_q <= CSIB0 ? wdog_q + WDOG_W'(1) : '0;
            else if (state_q == S_GRANT1)
                wdog_q <= CSIB1 ? wdog_q + WDOG_W'(1) : '0;
            else
                wdog_q <= '0;

            timeout0_q <= (state_q == S_GRANT0) & exp0;
            timeout1_q <= (state_q == S_GRANT1) & exp1;

            if ((state_q == S_GRANT0) && exp0) lock0_q <= 1'b1;
            else if (!REQ0)                    lock0_q <= 1'b0;
            if ((state_q == S_GRANT1) && exp1) lock1_q <= 1'b1;
            else if (!REQ1)                    lock1_q <= 1'b0;
        end
    end

    assign TIMEOUT0 = timeout0_q;
    assign TIMEOUT1 = timeout1_q;
`else
    assign exp0     = 1'b0;
    assign exp1     = 1'b0;
    assign req0_ok  = REQ0;
    assign req1_ok  = REQ1;
    assign TIMEOUT0 = 1'b0;
    assign TIMEOUT1 = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            armed_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            armed_q <= 1'b1;
            gnt0_q  <= (state_d == S_GRANT0);
            gnt1_q  <= (state_d == S_GRANT1);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            turn_cnt_q <= '0;
        else if (state_q == S_TURN)
            turn_cnt_q <= turn_cnt_q + CNT_W'(1);
        else
            turn_cnt_q <= '0;
    end

    // Release only on an idle CSIB so an in-flight ICAP transfer is never cut
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            S_IDLE: begin
                if (armed_q && ICAP_AVAIL) begin
                    if (req0_ok && (!req1_ok || !prio_q))
                        state_d = S_GRANT0;
                    else if (req1_ok)
                        state_d = S_GRANT1;
                end
            end
            S_GRANT0: begin
                if ((!REQ0 && CSIB0) || exp0) begin
                    state_d = S_TURN;
                    prio_d  = 1'b1;
                end
            end
            S_GRANT1: begin
                if ((!REQ1 && CSIB1) || exp1) begin
                    state_d = S_TURN;
                    prio_d  = 1'b0;
                end
            end
            S_TURN: begin
                if (turn_cnt_q == CNT_W'(TURNAROUND - 1))
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign GNT0       = gnt0_q;
    assign GNT1       = gnt1_q;
    assign AVAIL0     = ICAP_AVAIL & gnt0_q;
    assign AVAIL1     = ICAP_AVAIL & gnt1_q;
    assign O_REQ      = ICAP_O;
    assign ICAP_CSIB  = gnt0_q ? CSIB0  : (gnt1_q ? CSIB1  : 1'b1);
    assign ICAP_RDWRB = gnt0_q ? RDWRB0 : (gnt1_q ? RDWRB1 : 1'b1);
    assign ICAP_I     = gnt0_q ? I0     : (gnt1_q ? I1     : DATA_W'(0));

endmodule

// File: doc/icap_arbiter.md
ICAP_ARBITER -- requirements
Module: icap_arbiter

Interface
- REQ-001 SHALL have parameter TURNAROUND, default 2, number of forced-idle cycles (CSIB=1) between grants; legal range 1..15.
- REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, number of idle granted cycles before forced revoke; legal range 2..65535.
- REQ-003 SHALL have ports, in this order (clock and reset first):
  CLK  in  1  sole clock; ICAP clock.
  RESETN  in  1  asynchronous, active-low reset.
  REQ0, REQ1  in  1 each  access request; REQ0 is the PR controller, REQ1 the user/readback master.
  GNT0, GNT1  out  1 each  access grant.
  CSIB0/1, RDWRB0/1  in  1 each  requester ICAP controls.
  I0/I1  in  32 each  requester write data.
  AVAIL0/1  out  1 each  ICAP AVAIL gated by the grant.
  O_REQ  out  32  ICAP read data, broadcast to both requesters.
  TIMEOUT0/1  out  1 each  one-cycle revoke pulse.
  ICAP_CSIB, ICAP_RDWRB  out  1 each  controls driven to the ICAP.
  ICAP_I  out  32  data driven to the ICAP.
  ICAP_AVAIL  in  1  ICAP availability.
  ICAP_O  in  32  ICAP read data.

Function
- REQ-004 SHALL implement state machine IDLE, GRANT0, GRANT1, TURN; GNTn=1 exactly when state is GRANTn.
- REQ-005 IDLE: SHALL stay while ICAP_AVAIL=0 or no request; when ICAP_AVAIL=1 and a request is present, SHALL enter GRANTn on the next edge, so grant latency is 1 cycle from a REQ sampled high.
- REQ-006 Simultaneous REQ0 and REQ1 in IDLE SHALL be resolved round-robin. After reset port 0 has priority. After a grant to port n ends, the other port has priority.
- REQ-007 GRANTn: ICAP_CSIB, ICAP_RDWRB and ICAP_I SHALL combinationally follow CSIBn, RDWRBn and In (0-cycle latency).
- REQ-008 Outside GRANTn: ICAP_CSIB=1, ICAP_RDWRB=1 and ICAP_I=0; CSIB/RDWRB/I of the non-granted port SHALL be ignored.
- REQ-009 AVAILn SHALL equal ICAP_AVAIL AND GNTn.
- REQ-010 O_REQ SHALL equal ICAP_O in every state.
- REQ-011 GRANTn to TURN SHALL occur only when REQn=0 and CSIBn=1 in the same cycle.
- REQ-012 If REQn drops while CSIBn=0, the grant SHALL be held until CSIBn=1, so that no ICAP transfer is truncated.
- REQ-013 TURN SHALL last exactly TURNAROUND cycles, counted by a 4-bit counter, then go to IDLE; requests arriving during TURN SHALL wait.
- REQ-014 A requester SHALL keep REQn high while it needs access; re-requesting after release SHALL go through TURN and IDLE again, with no back-to-back re-grant.

Reset
- REQ-015 While RESETN=0, asynchronously: state=IDLE, GNT0/1=0, TIMEOUT0/1=0, counters=0, priority=port 0, ICAP_CSIB=1, ICAP_RDWRB=1, ICAP_I=0.
- REQ-016 Reset asserted mid-grant SHALL deassert ICAP_CSIB immediately, without waiting for a clock edge.
- REQ-017 Deassertion SHALL be recognised on the next CLK edge; no grant SHALL issue earlier than the second edge after RESETN rises.

Configuration
- REQ-018 Macro ICAP_ARB_TIMEOUT_EN SHALL compile the grant watchdog in or out.
- REQ-019 With ICAP_ARB_TIMEOUT_EN: in GRANTn a 16-bit counter SHALL clear on any cycle with CSIBn=0 and increment otherwise.
- REQ-020 With ICAP_ARB_TIMEOUT_EN: when the counter reaches TIMEOUT_CYCLES-1 with CSIBn=1, the block SHALL go to TURN and pulse TIMEOUTn for 1 cycle, even if REQn=1.
- REQ-021 With ICAP_ARB_TIMEOUT_EN: after a revoke, port n SHALL not be re-granted until REQn has been seen low for at least 1 cycle.
- REQ-022 Without ICAP_ARB_TIMEOUT_EN: TIMEOUT0/1 SHALL be tied to 0, no watchdog logic SHALL exist, and a grant SHALL be held indefinitely.

Verification
- REQ-023 Single request: ICAP_AVAIL=1, REQ0 rises at cycle 0 -> GNT0=1 from cycle 1; ICAP_I=I0 the same cycle; REQ0 falls with CSIB0=1 -> GNT0=0 next edge; ICAP_CSIB=1 for 2 cycles, then IDLE.
- REQ-024 Contention: REQ0 and REQ1 high together from reset -> GNT0 first. After REQ0 releases -> GNT1 at release+TURNAROUND+2 cycles. Both re-request -> GNT1 is not granted first next; port 0 wins.
- REQ-025 Mid-transfer release: REQ1 drops while CSIB1=0 for 5 more cycles -> GNT1 held 5 cycles; TURN entered on the first cycle with CSIB1=1.
- REQ-026 AVAIL gating: ICAP_AVAIL=0 with REQ0=1 -> no grant; ICAP_AVAIL rises -> GNT0 next edge; AVAIL1 stays 0 throughout.
- REQ-027 Reset: RESETN pulled low while GRANT1 and CSIB1=0 -> ICAP_CSIB=1 and GNT1=0 within the same cycle, without a clock edge.
- REQ-028 With ICAP_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: REQ0=1 and CSIB0=1 held -> TIMEOUT0 pulses on the 16th granted cycle, GNT0 drops, and no re-grant occurs until REQ0 toggles.
